lut_ram_dma: RTL and testbench

Block-transfer initiator for a `lut_ram` (combinational read, clocked write). It accepts one copy or fill command and drives the RAM's `wr_en`/`wr_addr`/`rd_addr`/`wr_data` port, consuming `rd_data` at one word per cycle. It sits between the control path and a scratch `lut_ram`, replacing word-by-word software loops for memory clears and block moves.

---
 rtl/lut_ram_dma_pkg.sv | 13 +
 rtl/riscv_32i_defs_pkg.sv | 4 +
 rtl/lut_ram_dma_range_chk.sv | 37 +++
 rtl/lut_ram_dma.sv | 136 +++++++++++++
 tb/tb_lut_ram_dma.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_ram_dma_pkg.sv
// rtl/lut_ram_dma_pkg.sv - command and state types for the lut_ram block-transfer engine
package lut_ram_dma_pkg;
    typedef enum logic {
        OP_COPY = 1'b0,
        OP_FILL = 1'b1
    } dma_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dma_state_e;
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - shared RV32I core definitions used for datapath widths
package riscv_32i_defs_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/lut_ram_dma_range_chk.sv
// rtl/lut_ram_dma_range_chk.sv - combinational command classification for lut_ram_dma
// Ports:
//   op, src_addr, dst_addr, len : command fields as presented with start
//   range_err  : a copy source or destination window runs past the end of the RAM
//   zero_len   : nothing to transfer
//   descending : overlapping copy with dst above src, so it must run high-to-low
module lut_ram_dma_range_chk
    import lut_ram_dma_pkg::*;
#(
    parameter  int LUT_DEPTH = 256,
    localparam int ADDR_W    = $clog2(LUT_DEPTH),
    localparam int LEN_W     = ADDR_W + 1
) (
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              range_err,
    output logic              zero_len,
    output logic              descending
);
    // One bit wider than len so base+len can never wrap.
    localparam logic [LEN_W:0] LIMIT = (LEN_W + 1)'(LUT_DEPTH);

    logic [LEN_W:0] src_end;
    logic [LEN_W:0] dst_end;
    logic           is_copy;

    assign is_copy    = (op == OP_COPY);
    assign src_end    = {2'b00, src_addr} + {1'b0, len};
    assign dst_end    = {2'b00, dst_addr} + {1'b0, len};
    assign range_err  = (dst_end > LIMIT) || (is_copy && (src_end > LIMIT));
    assign zero_len   = (len == '0);
    // A destination starting inside the source window would overwrite source
    // words before they are read if the copy ran upward.
    assign descending = is_copy && (src_addr < dst_addr) && ({2'b00, dst_addr} < src_end);
endmodule

// File: rtl/lut_ram_dma.sv
// rtl/lut_ram_dma.sv - copy/fill block-transfer initiator driving a combinational-read lut_ram
// Ports:
//   clk, rst (sync, active-high)
//   start, op, src_addr, dst_addr, len, fill_data : command, sampled only in IDLE
//   busy  : transfer in progress; done/err : one-cycle completion pulses
//   mem_wr_en, mem_wr_addr, mem_rd_addr, mem_wr_data, mem_rd_data : RAM side
module lut_ram_dma
    import lut_ram_dma_pkg::*;
#(
    parameter  int LUT_WIDTH = riscv_32i_defs_pkg::XLEN,
    parameter  int LUT_DEPTH = 256,
    localparam int ADDR_W    = $clog2(LUT_DEPTH),
    localparam int LEN_W     = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len,
    input  logic [LUT_WIDTH-1:0] fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    output logic [LUT_WIDTH-1:0] mem_wr_data,
    input  logic [LUT_WIDTH-1:0] mem_rd_data
);
    dma_state_e           state;
    dma_state_e           state_nxt;
    dma_op_e              op_q;
    logic [LUT_WIDTH-1:0] fill_q;
    logic [LEN_W-1:0]     remaining;
    logic [ADDR_W-1:0]    src_ptr;
    logic [ADDR_W-1:0]    dst_ptr;
    logic                 desc_q;
    logic                 err_q;

    logic                 range_err;
    logic                 zero_len;
    logic                 descending;
    logic [ADDR_W-1:0]    last_off;

    lut_ram_dma_range_chk #(
        .LUT_DEPTH (LUT_DEPTH)
    ) u_range_chk (
        .op         (op),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .range_err  (range_err),
        .zero_len   (zero_len),
        .descending (descending)
    );

    // Offset of the last word; only meaningful when the command goes to RUN,
    // where len is 1..LUT_DEPTH and the result fits ADDR_W bits.
    assign last_off = ADDR_W'(len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_COPY;
            fill_q    <= '0;
            remaining <= '0;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            desc_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                op_q      <= dma_op_e'(op);
                fill_q    <= fill_data;
                remaining <= len;
                err_q     <= range_err;
                desc_q    <= descending;
                src_ptr   <= descending ? src_addr + last_off : src_addr;
                dst_ptr   <= descending ? dst_addr + last_off : dst_addr;
            end else if (state == RUN) begin
                remaining <= remaining - LEN_W'(1);
                src_ptr   <= desc_q ? src_ptr - ADDR_W'(1) : src_ptr + ADDR_W'(1);
                dst_ptr   <= desc_q ? dst_ptr - ADDR_W'(1) : dst_ptr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (range_err || zero_len) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is asserted so a reset landing mid-RUN
    // also blocks the write that would otherwise commit on that same edge.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_rd_addr = '0;
        mem_wr_data = '0;
        if (!rst) begin
            case (state)
                RUN: begin
                    busy        = 1'b1;
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = dst_ptr;
                    mem_rd_addr = src_ptr;
                    mem_wr_data = (op_q == OP_FILL) ? fill_q : mem_rd_data;
                end
                DONE: begin
                    done = 1'b1;
                    err  = err_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_ram_dma.sv
// tb/tb_lut_ram_dma.sv - scoreboard bench for lut_ram_dma against a behavioural lut_ram
module tb_lut_ram_dma;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int LW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic [W-1:0]  fill_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data;

    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [W-1:0]  tb_wd;

    logic [W-1:0]  ram     [D];
    logic [W-1:0]  ref_mem [D];
    wr_t           sb[$];

    int checks = 0;
    int errors = 0;

    lut_ram_dma #(
        .LUT_WIDTH (W),
        .LUT_DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .fill_data   (fill_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural lut_ram: clocked write, combinational read; bench preload port.
    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) ram[mem_wr_addr] <= mem_wr_data;
        else if (tb_we) ram[tb_wa] <= tb_wd;
    end
    assign mem_rd_data = ram[mem_rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every RAM write is popped from the scoreboard in issue order.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            check("write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(mem_wr_addr), 64'(e.a));
                check("wr_data", 64'(mem_wr_data), 64'(e.d));
            end
        end
    end

    task automatic preload();
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            tb_we = 1'b1;
            tb_wa = AW'(i);
            tb_wd = W'(i);
            ref_mem[i] = W'(i);
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < D; i++) check(tag, 64'(ram[i]), 64'(ref_mem[i]));
    endtask

    // Reference behaviour: memmove semantics, with the write order an
    // overlapping upward move needs to be safe.
    task automatic push_expected(input logic o, input int s, input int d, input int l,
                                 input logic [W-1:0] f);
        logic [W-1:0] old [D];
        bit desc;
        for (int i = 0; i < D; i++) old[i] = ref_mem[i];
        desc = (o == 1'b0) && (s < d) && (d < s + l);
        for (int k = 0; k < l; k++) begin
            int  i;
            wr_t e;
            i   = desc ? (l - 1 - k) : k;
            e.a = AW'(d + i);
            e.d = o ? f : old[s + i];
            sb.push_back(e);
            ref_mem[d + i] = e.d;
        end
    endtask

    task automatic do_cmd(input string tag, input logic o, input int s, input int d, input int l,
                          input logic [W-1:0] f, input logic exp_err, input bit poke);
        int cyc;
        int busy_cnt;
        bit seen;
        bit quick;
        quick = exp_err || (l == 0);
        if (!quick) push_expected(o, s, d, l, f);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        src_addr  = AW'(s);
        dst_addr  = AW'(d);
        len       = LW'(l);
        fill_data = f;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && poke) begin
                op = 1'b1; dst_addr = '0; len = LW'(2); fill_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_err"}, 64'(err), 64'(exp_err));
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(cyc), quick ? 64'd1 : 64'(l + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), quick ? 64'd0 : 64'(l));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int  dseen;
        wr_t e;
        rst = 1'b1; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_wr_en", 64'(mem_wr_en), 64'd0);
        check("reset_wr_addr", 64'(mem_wr_addr), 64'd0);
        check("reset_rd_addr", 64'(mem_rd_addr), 64'd0);
        check("reset_wr_data", 64'(mem_wr_data), 64'd0);

        preload();
        do_cmd("fill", 1'b1, 0, 4, 5, 32'hA5A5_A5A5, 1'b0, 1'b0);
        preload();
        do_cmd("copy_disjoint", 1'b0, 0, 8, 4, '0, 1'b0, 1'b0);
        preload();
        do_cmd("copy_overlap", 1'b0, 2, 4, 6, '0, 1'b0, 1'b0);
        preload();
        do_cmd("copy_down_overlap", 1'b0, 4, 2, 6, '0, 1'b0, 1'b0);
        do_cmd("fill_oor", 1'b1, 0, 12, 5, 32'h1111_1111, 1'b1, 1'b0);
        do_cmd("copy_src_oor", 1'b0, 14, 0, 4, '0, 1'b1, 1'b0);
        do_cmd("fill_edge", 1'b1, 0, 12, 4, 32'h7E7E_0001, 1'b0, 1'b0);
        do_cmd("copy_full", 1'b0, 0, 0, 16, '0, 1'b0, 1'b0);
        do_cmd("zero_len", 1'b1, 0, 3, 0, 32'h2222_2222, 1'b0, 1'b0);
        do_cmd("start_ignored", 1'b1, 0, 10, 4, 32'h5A5A_0000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("start_ignored_stays_idle", 64'(busy), 64'd0);

        // Reset on the third RUN cycle of a ten-word fill: only words 0 and 1 land.
        for (int i = 0; i < 2; i++) begin
            e.a = AW'(i);
            e.d = 32'h3C3C_3C3C;
            sb.push_back(e);
            ref_mem[i] = e.d;
        end
        @(negedge clk);
        start = 1'b1; op = 1'b1; dst_addr = '0; src_addr = '0; len = LW'(10);
        fill_data = 32'h3C3C_3C3C;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", 64'(mem_wr_en), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_after_busy", 64'(busy), 64'd0);
        check("rst_after_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_after_done", 64'(done), 64'd0);
        dseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dseen++;
        end
        check("rst_no_done", 64'(dseen), 64'd0);
        check("rst_sb_empty", 64'(sb.size()), 64'd0);
        check_mem("rst_mem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
